// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit 7-segment scan driver for cascaded 74HC595s
// Define SEG_HEX_EN to show A-F for digit values 10-15; otherwise those digits are blank.
module seg_scan_driver #(
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        GCLK,
  input  logic        rst_n,
  input  logic [15:0] val_in,
  input  logic        val_valid,
  output logic        val_ready,
  output logic        clockPin,
  output logic        dataPin,
  output logic        latchPin,
  output logic        busy
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, WAIT} state_t;

  state_t        state_q, state_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          shadow_full_q, shadow_full_d;
  logic [15:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          clk_q, clk_d, data_q, data_d, latch_q, latch_d, busy_q, busy_d;
  logic [15:0]   shown;
  logic [3:0]    nibble;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 8'hC0;
      4'h1: seg_decode = 8'hF9;
      4'h2: seg_decode = 8'hA4;
      4'h3: seg_decode = 8'hB0;
      4'h4: seg_decode = 8'h99;
      4'h5: seg_decode = 8'h92;
      4'h6: seg_decode = 8'h82;
      4'h7: seg_decode = 8'hF8;
      4'h8: seg_decode = 8'h80;
      4'h9: seg_decode = 8'h90;
`ifdef SEG_HEX_EN
      4'hA: seg_decode = 8'h88;
      4'hB: seg_decode = 8'h83;
      4'hC: seg_decode = 8'hC6;
      4'hD: seg_decode = 8'hA1;
      4'hE: seg_decode = 8'h86;
      4'hF: seg_decode = 8'h8E;
`endif
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    word_d        = word_q;
    idx_d         = idx_q;
    bit_d         = bit_q;
    phase_d       = phase_q;
    refresh_d     = (refresh_q == RF_LAST) ? refresh_q : refresh_q + 1'b1;
    shown         = active_q;
    nibble        = 4'h0;

    if (val_valid && !shadow_full_q) begin
      shadow_d      = val_in;
      shadow_full_d = 1'b1;
    end

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        // New values only take effect at digit 0 so a frame set never mixes two values.
        if (idx_q == 2'd0 && shadow_full_q) begin
          shown         = shadow_q;
          active_d      = shadow_q;
          shadow_full_d = 1'b0;
        end
        nibble  = shown[{idx_q, 2'b00} +: 4];
        word_d  = {seg_decode(nibble), 4'hF, ~(4'b0001 << idx_q)};
        bit_d   = 5'd0;
        phase_d = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          word_d  = {word_q[14:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 5'd15) ? LATCH : SHIFT_LO;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      LATCH: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          state_d = WAIT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      WAIT: begin
        if (refresh_q == RF_LAST) begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // The refresh period is measured from each LOAD; it saturates if the frame outlasts it.
    if (state_d == LOAD) refresh_d = '0;

    // Pins are registered copies of what the next state drives.
    clk_d   = (state_d == SHIFT_HI);
    latch_d = (state_d == LATCH);
    data_d  = (state_d == SHIFT_LO || state_d == SHIFT_HI) ? word_d[15] : 1'b0;
    busy_d  = (state_d inside {LOAD, SHIFT_LO, SHIFT_HI, LATCH});
  end

  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      word_q        <= '0;
      idx_q         <= '0;
      bit_q         <= '0;
      phase_q       <= '0;
      refresh_q     <= '0;
      clk_q         <= 1'b0;
      data_q        <= 1'b0;
      latch_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      bit_q         <= bit_d;
      phase_q       <= phase_d;
      refresh_q     <= refresh_d;
      clk_q         <= clk_d;
      data_q        <= data_d;
      latch_q       <= latch_d;
      busy_q        <= busy_d;
    end
  end

  assign val_ready = !shadow_full_q;
  assign clockPin  = clk_q;
  assign dataPin   = data_q;
  assign latchPin  = latch_q;
  assign busy      = busy_q;
endmodule
